// File: rtl/stream_dup_map_pkg.sv
// rtl/stream_dup_map_pkg.sv - shared state encoding, map opcodes and map function for stream_dup_map_n
package stream_dup_map_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int OP_ADD = 0;
    localparam int OP_XOR = 1;
    localparam int OP_SHL = 2;

    // Works on a 64-bit carrier; callers truncate to their own width, which
    // gives the mod 2^WIDTH wrap and drops bits shifted out of the top.
    function automatic logic [63:0] map_f(input int op, input logic [63:0] k,
                                          input logic [63:0] x);
        case (op)
            OP_XOR:  return x ^ k;
            OP_SHL:  return x << k[2:0];
            default: return x + k;
        endcase
    endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// rtl/stream_hold_reg.sv - one-entry registered output stage that repeats each loaded value DUP times
//
// Ports:
//   clk, nrst       clock, asynchronous active-low reset
//   load, load_data load a new value (only legal while free is high)
//   data, valid     registered output element
//   ready           downstream consumes data when valid & ready
//   copy            index of the copy currently presented (0..DUP-1)
//   free            stage can take a load this cycle (empty, or last copy leaving now)
module stream_hold_reg
    import stream_dup_map_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DUP   = 2,
    parameter int CW    = $clog2(DUP + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic [CW-1:0]    copy,
    output logic             free
);

    logic last;

    assign last = (copy == CW'(DUP - 1));
    // Combinational bypass: the final copy leaving frees the slot in the same cycle.
    assign free = !valid || (ready && last);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            data  <= '0;
            valid <= 1'b0;
            copy  <= '0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
            copy  <= '0;
        end else if (valid && ready) begin
            if (last) begin
                valid <= 1'b0;
            end else begin
                copy <= copy + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_dup_map_n.sv
// rtl/stream_dup_map_n.sv - activation-driven stream block emitting DUP copies of f(x) per input element
//
// Optional feature macro: STREAM_DUP_MAP_TAG_EN adds sOut_tag (copy index) and sOut_last.
//
// Ports:
//   clk, nrst                 clock, asynchronous active-low reset
//   in_valid, in_ready        activation handshake (in_ready high only in IDLE)
//   out_valid, out_ready      run-complete handshake (out_valid held in DONE)
//   sIn, sIn_valid, sIn_ready input element stream
//   sOut, sOut_valid, sOut_ready registered output element stream
//   sOut_tag, sOut_last       copy index / final-copy flag (macro builds only)
module stream_dup_map_n
    import stream_dup_map_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DUP   = 2,
    parameter int               COUNT = 0,
    parameter int               OP    = 0,
    parameter logic [WIDTH-1:0] K     = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [WIDTH-1:0] sIn,
    input  logic             sIn_valid,
    output logic             sIn_ready,
    output logic [WIDTH-1:0] sOut,
    output logic             sOut_valid,
    input  logic             sOut_ready
`ifdef STREAM_DUP_MAP_TAG_EN
    ,
    output logic [7:0]       sOut_tag,
    output logic             sOut_last
`endif
);

    localparam int CW = $clog2(DUP + 1);

    state_t           state;
    logic [31:0]      elem_cnt;
    logic [CW-1:0]    copy;
    logic [WIDTH-1:0] mapped;
    logic             stage_free;
    logic             cnt_open;
    logic             accept;
    logic             consume;
    logic             last_copy;
    logic             finish;

    assign mapped    = WIDTH'(map_f(OP, 64'(K), 64'(sIn)));
    // Once COUNT elements are taken the run stops pulling input while it drains.
    assign cnt_open  = (COUNT == 0) || (elem_cnt < 32'(COUNT));
    assign sIn_ready = (state == ST_RUN) && stage_free && cnt_open;
    assign accept    = sIn_valid && sIn_ready;
    assign consume   = sOut_valid && sOut_ready;
    assign last_copy = (copy == CW'(DUP - 1));
    assign finish    = (COUNT != 0) && consume && last_copy && !accept
                       && (elem_cnt == 32'(COUNT));

    stream_hold_reg #(
        .WIDTH (WIDTH),
        .DUP   (DUP),
        .CW    (CW)
    ) u_hold (
        .clk       (clk),
        .nrst      (nrst),
        .load      (accept),
        .load_data (mapped),
        .data      (sOut),
        .valid     (sOut_valid),
        .ready     (sOut_ready),
        .copy      (copy),
        .free      (stage_free)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            elem_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= ST_RUN;
                        in_ready <= 1'b0;
                        elem_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    // Saturating count keeps unbounded runs from wrapping.
                    if (accept && (elem_cnt != '1)) begin
                        elem_cnt <= elem_cnt + 32'd1;
                    end
                    if (finish) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef STREAM_DUP_MAP_TAG_EN
    assign sOut_tag  = 8'(copy);
    assign sOut_last = sOut_valid && last_copy;
`endif

endmodule

// File: tb/tb_stream_dup_map_n.sv
// tb/tb_stream_dup_map_n.sv - self-checking bench for stream_dup_map_n (four parameter sets)
module tb_stream_dup_map_n;

    localparam int NU = 4;

    logic       clk;
    logic       nrst;
    logic       in_valid    [NU];
    logic       in_ready    [NU];
    logic       out_valid   [NU];
    logic       out_ready   [NU];
    logic [7:0] s_in        [NU];
    logic       s_in_valid  [NU];
    logic       s_in_ready  [NU];
    logic [7:0] s_out       [NU];
    logic       s_out_valid [NU];
    logic       s_out_ready [NU];

    int n_checks = 0;
    int n_fail   = 0;

    // Unit 0: DUP=2 add 1 COUNT=3; unit 1: DUP=3 add 1 unbounded;
    // unit 2: DUP=1 xor FF COUNT=8; unit 3: DUP=1 shl 1 unbounded.
    stream_dup_map_n #(.WIDTH(8), .DUP(2), .COUNT(3), .OP(0), .K(8'h01)) u_a (
        .clk(clk), .nrst(nrst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sIn(s_in[0]),
        .sIn_valid(s_in_valid[0]), .sIn_ready(s_in_ready[0]), .sOut(s_out[0]),
        .sOut_valid(s_out_valid[0]), .sOut_ready(s_out_ready[0]));
    stream_dup_map_n #(.WIDTH(8), .DUP(3), .COUNT(0), .OP(0), .K(8'h01)) u_b (
        .clk(clk), .nrst(nrst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sIn(s_in[1]),
        .sIn_valid(s_in_valid[1]), .sIn_ready(s_in_ready[1]), .sOut(s_out[1]),
        .sOut_valid(s_out_valid[1]), .sOut_ready(s_out_ready[1]));
    stream_dup_map_n #(.WIDTH(8), .DUP(1), .COUNT(8), .OP(1), .K(8'hFF)) u_c (
        .clk(clk), .nrst(nrst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sIn(s_in[2]),
        .sIn_valid(s_in_valid[2]), .sIn_ready(s_in_ready[2]), .sOut(s_out[2]),
        .sOut_valid(s_out_valid[2]), .sOut_ready(s_out_ready[2]));
    stream_dup_map_n #(.WIDTH(8), .DUP(1), .COUNT(0), .OP(2), .K(8'h01)) u_d (
        .clk(clk), .nrst(nrst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .sIn(s_in[3]),
        .sIn_valid(s_in_valid[3]), .sIn_ready(s_in_ready[3]), .sOut(s_out[3]),
        .sOut_valid(s_out_valid[3]), .sOut_ready(s_out_ready[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dup_of(input int u);
        case (u)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int cnt_of(input int u);
        case (u)
            0:       return 3;
            2:       return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int model_f(input int u, input int x);
        case (u)
            2:       return (x ^ 255) & 255;
            3:       return (x * 2) & 255;
            default: return (x + 1) & 255;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each unit holds at most one element, presented as
    // m_pend remaining copies of m_val; plus the run/done activation state.
    int  m_val  [NU];
    int  m_pend [NU];
    int  m_acc  [NU];
    bit  m_run  [NU];
    bit  m_done [NU];

    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (!nrst) begin
                m_pend[u] = 0;
                m_acc[u]  = 0;
                m_run[u]  = 0;
                m_done[u] = 0;
            end else begin
                bit exp_ir;
                bit cons;
                bit acc;
                exp_ir = m_run[u] && (cnt_of(u) == 0 || m_acc[u] < cnt_of(u))
                         && (m_pend[u] == 0 || (m_pend[u] == 1 && s_out_ready[u]));
                chk("mon_sOut_valid", int'(s_out_valid[u]), int'(m_pend[u] > 0));
                if (m_pend[u] > 0) chk("mon_sOut", int'(s_out[u]), m_val[u]);
                chk("mon_sIn_ready", int'(s_in_ready[u]), int'(exp_ir));
                chk("mon_in_ready", int'(in_ready[u]), int'(!m_run[u] && !m_done[u]));
                chk("mon_out_valid", int'(out_valid[u]), int'(m_done[u]));
                cons = (m_pend[u] > 0) && s_out_ready[u];
                acc  = s_in_valid[u] && exp_ir;
                if (cons) m_pend[u]--;
                if (acc) begin
                    m_val[u]  = model_f(u, int'(s_in[u]));
                    m_pend[u] = dup_of(u);
                    m_acc[u]++;
                end
                if (m_run[u]) begin
                    if (cons && m_pend[u] == 0 && cnt_of(u) != 0 && m_acc[u] == cnt_of(u)) begin
                        m_run[u]  = 0;
                        m_done[u] = 1;
                    end
                end else if (m_done[u]) begin
                    if (out_ready[u]) m_done[u] = 0;
                end else if (in_valid[u]) begin
                    m_run[u] = 1;
                    m_acc[u] = 0;
                end
            end
        end
    end

    task automatic activate(input int u);
        @(posedge clk); #1;
        in_valid[u] = 1'b1;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
    endtask

    task automatic one_elem(input int u, input logic [7:0] x, input logic [7:0] exp);
        int n;
        int got;
        @(posedge clk); #1;
        s_in[u] = x; s_in_valid[u] = 1'b1; s_out_ready[u] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_in_ready[u] && n < 20);
        chk("elem_accept_seen", int'(s_in_ready[u]), 1);
        @(posedge clk); #1;
        s_in_valid[u] = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got < dup_of(u); c++) begin
            @(negedge clk);
            if (s_out_valid[u]) begin
                chk("elem_data", int'(s_out[u]), int'(exp));
                got++;
            end
        end
        chk("elem_copies", got, dup_of(u));
    endtask

    // Unit 0 run of three elements base..base+2; optional in_valid pulse mid-run.
    task automatic run_a(input int base, input bit pulse);
        int acc, nout, first, last, ov;
        acc = 0; nout = 0; first = -1; last = -1; ov = -1;
        activate(0);
        s_in[0] = 8'(base); s_in_valid[0] = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (s_out_valid[0] && s_out_ready[0]) begin
                chk("run_data", int'(s_out[0]), (base + 1 + nout / 2) & 255);
                if (nout == 0) first = cyc;
                last = cyc;
                nout++;
            end
            if (out_valid[0]) begin
                ov = cyc;
                break;
            end
            if (s_in_valid[0] && s_in_ready[0]) acc++;
            @(posedge clk); #1;
            s_in[0]       = 8'(base + acc);
            s_in_valid[0] = (acc < 3);
            in_valid[0]   = pulse && (cyc == 2);
        end
        s_in_valid[0] = 1'b0;
        in_valid[0]   = 1'b0;
        chk("run_count", nout, 6);
        chk("run_back_to_back", last - first, 5);
        chk("run_out_valid_time", ov, last + 1);
        @(posedge clk);
        @(negedge clk);
        chk("run_in_ready_back", int'(in_ready[0]), 1);
        chk("run_out_valid_drop", int'(out_valid[0]), 0);
    endtask

    typedef struct {
        int         u;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int acc, nout, n6, first, last;
        bit got2;
        nrst = 1'b0;
        for (int u = 0; u < NU; u++) begin
            in_valid[u] = 1'b0; out_ready[u] = 1'b1; s_in[u] = 8'h00;
            s_in_valid[u] = 1'b0; s_out_ready[u] = 1'b1;
        end
        tbl[0] = '{1, 8'hFF, 8'h00};
        tbl[1] = '{1, 8'h00, 8'h01};
        tbl[2] = '{1, 8'h7F, 8'h80};
        tbl[3] = '{3, 8'h81, 8'h02};
        tbl[4] = '{3, 8'h80, 8'h00};
        tbl[5] = '{3, 8'h7F, 8'hFE};
        tbl[6] = '{3, 8'h01, 8'h02};
        tbl[7] = '{1, 8'hA5, 8'hA6};

        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            chk("rst_in_ready", int'(in_ready[u]), 1);
            chk("rst_out_valid", int'(out_valid[u]), 0);
            chk("rst_sOut_valid", int'(s_out_valid[u]), 0);
            chk("rst_sIn_ready", int'(s_in_ready[u]), 0);
            chk("rst_sOut", int'(s_out[u]), 0);
        end
        @(posedge clk); #1;
        nrst = 1'b1;

        run_a(0, 1'b0);
        run_a(16, 1'b1);

        activate(1);
        activate(3);
        for (int i = 0; i < 8; i++) one_elem(tbl[i].u, tbl[i].din, tbl[i].dout);

        // Backpressure on unit 1: sIn_ready may return only with the third consume.
        acc = 0; n6 = 0; got2 = 0;
        @(posedge clk); #1;
        s_in[1] = 8'd5; s_in_valid[1] = 1'b1; s_out_ready[1] = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (s_out_valid[1] && s_out_ready[1] && n6 < 3) begin
                chk("bp_data", int'(s_out[1]), 6);
                n6++;
            end
            if (s_in_valid[1] && s_in_ready[1]) begin
                if (acc == 0) acc = 1;
                else begin
                    chk("bp_ready_on_third", n6, 3);
                    got2 = 1;
                    break;
                end
            end
            @(posedge clk); #1;
            s_in[1] = (acc == 1) ? 8'd9 : 8'd5;
            s_out_ready[1] = ~s_out_ready[1];
        end
        chk("bp_second_accept", int'(got2), 1);
        @(posedge clk); #1;
        s_in_valid[1] = 1'b0; s_out_ready[1] = 1'b1;
        repeat (6) @(posedge clk);

        // Full rate on unit 2: one element in and one out every cycle.
        activate(2);
        acc = 0; nout = 0; first = -1; last = -1;
        s_in[2] = 8'd0; s_in_valid[2] = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (s_out_valid[2] && s_out_ready[2]) begin
                chk("fr_data", int'(s_out[2]), 255 - nout);
                if (nout == 0) first = cyc;
                last = cyc;
                nout++;
            end
            if (out_valid[2]) break;
            if (acc < 8) chk("fr_sIn_ready", int'(s_in_ready[2]), 1);
            if (s_in_valid[2] && s_in_ready[2]) acc++;
            @(posedge clk); #1;
            s_in[2] = 8'(acc); s_in_valid[2] = (acc < 8);
        end
        s_in_valid[2] = 1'b0;
        chk("fr_count", nout, 8);
        chk("fr_back_to_back", last - first, 7);
        repeat (2) @(posedge clk);

        // Reset mid-run on unit 1 while the second copy is presented.
        @(posedge clk); #1;
        s_in[1] = 8'h20; s_in_valid[1] = 1'b1; s_out_ready[1] = 1'b1;
        acc = 0;
        do begin
            @(negedge clk);
            acc++;
        end while (!s_in_ready[1] && acc < 20);
        @(posedge clk); #1;
        s_in_valid[1] = 1'b0;
        @(posedge clk); #1;
        s_out_ready[1] = 1'b0;
        @(negedge clk);
        chk("mid_sOut_valid", int'(s_out_valid[1]), 1);
        chk("mid_sOut", int'(s_out[1]), 8'h21);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_sOut_valid", int'(s_out_valid[1]), 0);
        chk("mid_rst_sOut", int'(s_out[1]), 0);
        chk("mid_rst_in_ready", int'(in_ready[1]), 1);
        chk("mid_rst_sIn_ready", int'(s_in_ready[1]), 0);
        chk("mid_rst_d_in_ready", int'(in_ready[3]), 1);
        @(posedge clk);
        @(posedge clk); #1;
        s_out_ready[1] = 1'b1;
        nrst = 1'b1;
        activate(1);
        one_elem(1, 8'h41, 8'h42);

        // Randomised traffic on all units, checked by the reference model.
        for (int r = 0; r < 800; r++) begin
            @(posedge clk); #1;
            for (int u = 0; u < NU; u++) begin
                s_in[u]        = 8'($urandom);
                s_in_valid[u]  = ($urandom_range(0, 9) < 7);
                s_out_ready[u] = ($urandom_range(0, 3) != 0);
                in_valid[u]    = ($urandom_range(0, 3) == 0);
                out_ready[u]   = ($urandom_range(0, 1) == 0);
            end
        end
        @(posedge clk); #1;
        for (int u = 0; u < NU; u++) begin
            s_in_valid[u] = 1'b0; in_valid[u] = 1'b0;
            s_out_ready[u] = 1'b1; out_ready[u] = 1'b1;
        end
        repeat (6) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
